tcdm_bank_rr_arbiter: RTL and testbench

- Shares one single-ported TCDM SRAM bank between NumCores core data ports that use the cluster core data request/response format (req/add/we/data/be -> gnt/r_data/r_valid).
- Arbitration is round-robin with a same-cycle grant.
- Read and write responses return one cycle after the grant.
- A saturating conflict counter is exposed for performance monitoring.
- The block sits between the per-core LSU demux and each TCDM bank when HCI is disabled (UseHci=0).

---
 rtl/tcdm_bank_rr_arbiter_if.sv | 39 +++
 rtl/tcdm_bank_rr_arbiter.sv | 110 +++++++++++
 tb/tb_tcdm_bank_rr_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_bank_rr_arbiter_if.sv
// rtl/tcdm_bank_rr_arbiter_if.sv - core-port and bank-port bundle for the TCDM bank arbiter
interface tcdm_bank_rr_arbiter_if #(
  parameter int unsigned NumCores  = 8,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  // core side: request channel
  logic [NumCores-1:0]                    req_i;
  logic [NumCores-1:0][AddrWidth-1:0]     add_i;
  logic [NumCores-1:0]                    we_i;
  logic [NumCores-1:0][DataWidth-1:0]     data_i;
  logic [NumCores-1:0][DataWidth/8-1:0]   be_i;
  // core side: grant and response
  logic [NumCores-1:0]                    gnt_o;
  logic [NumCores-1:0][DataWidth-1:0]     r_data_o;
  logic [NumCores-1:0]                    r_valid_o;
  // bank side
  logic                                   mem_req_o;
  logic                                   mem_we_o;
  logic [AddrWidth-1:0]                   mem_addr_o;
  logic [DataWidth-1:0]                   mem_wdata_o;
  logic [DataWidth/8-1:0]                 mem_be_o;
  logic                                   mem_gnt_i;
  logic [DataWidth-1:0]                   mem_rdata_i;

  // requesters plus the bank model
  modport master (
    output req_i, add_i, we_i, data_i, be_i, mem_gnt_i, mem_rdata_i,
    input  gnt_o, r_data_o, r_valid_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  // the arbiter itself
  modport slave (
    input  req_i, add_i, we_i, data_i, be_i, mem_gnt_i, mem_rdata_i,
    output gnt_o, r_data_o, r_valid_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/tcdm_bank_rr_arbiter.sv
// rtl/tcdm_bank_rr_arbiter.sv - round-robin arbiter sharing one TCDM bank between core ports
module tcdm_bank_rr_arbiter #(
  parameter int unsigned NumCores  = 8,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  tcdm_bank_rr_arbiter_if.slave      bus,
  input  logic                       clr_cnt_i,
  output logic [CntWidth-1:0]        conflict_cnt_o
);

  localparam int unsigned PtrWidth = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam int unsigned IdxWidth = PtrWidth + 1;
  localparam logic [IdxWidth-1:0] NumIdx  = IdxWidth'(NumCores);
  localparam logic [PtrWidth-1:0] LastIdx = PtrWidth'(NumCores - 1);
  localparam logic [NumCores-1:0] OneReq  = NumCores'(1);

  logic [PtrWidth-1:0] rr_q;
  logic [PtrWidth-1:0] rr_next;
  logic                rsp_valid_q;
  logic [PtrWidth-1:0] rsp_idx_q;
  logic [CntWidth-1:0] cnt_q;

  logic [PtrWidth-1:0] winner;
  logic                found;
  logic [IdxWidth-1:0] cand;
  logic                accept;
  logic                conflict;

  // Search from rr_q upward with explicit wrap so non-power-of-two port counts stay in range
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NumCores; k++) begin
      cand = {1'b0, rr_q} + IdxWidth'(k);
      if (cand >= NumIdx) begin
        cand = cand - NumIdx;
      end
      if (!found && bus.req_i[cand[PtrWidth-1:0]]) begin
        winner = cand[PtrWidth-1:0];
        found  = 1'b1;
      end
    end
  end

  assign accept   = found & bus.mem_gnt_i;
  // clearing the lowest set bit leaves something only when two or more ports request
  assign conflict = |(bus.req_i & (bus.req_i - OneReq));
  assign rr_next  = (winner == LastIdx) ? '0 : winner + 1'b1;

  // Bank-side mux and the single grant; data outputs stay at zero with no request
  always_comb begin
    bus.mem_req_o   = |bus.req_i;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_be_o    = '0;
    bus.gnt_o       = '0;
    if (found) begin
      bus.mem_we_o      = bus.we_i[winner];
      bus.mem_addr_o    = bus.add_i[winner];
      bus.mem_wdata_o   = bus.data_i[winner];
      bus.mem_be_o      = bus.be_i[winner];
      bus.gnt_o[winner] = bus.mem_gnt_i;
    end
  end

  // Steer the bank's read data back to the port granted in the previous cycle
  always_comb begin
    bus.r_valid_o = '0;
    bus.r_data_o  = '0;
    if (rsp_valid_q) begin
      bus.r_valid_o[rsp_idx_q] = 1'b1;
      bus.r_data_o[rsp_idx_q]  = bus.mem_rdata_i;
    end
  end

  // Pointer and response tracking advance only on an accepted bank transfer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rr_q      <= rr_next;
        rsp_idx_q <= winner;
      end
    end
  end

  // Saturating conflict counter; a clear wins over a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// tb/tb_tcdm_bank_rr_arbiter.sv - scoreboard bench for the TCDM bank round-robin arbiter
module tb_tcdm_bank_rr_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [CW-1:0] cnt;
  logic clr3;
  logic [15:0] cnt3;

  always #5 clk = ~clk;

  tcdm_bank_rr_arbiter_if #(.NumCores(NC), .AddrWidth(AW), .DataWidth(DW)) bus ();
  tcdm_bank_rr_arbiter_if #(.NumCores(3), .AddrWidth(AW), .DataWidth(DW)) bus3 ();

  tcdm_bank_rr_arbiter #(.NumCores(NC), .AddrWidth(AW), .DataWidth(DW), .CntWidth(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .clr_cnt_i      (clr),
    .conflict_cnt_o (cnt)
  );

  tcdm_bank_rr_arbiter #(.NumCores(3), .AddrWidth(AW), .DataWidth(DW), .CntWidth(16)) dut3 (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus3),
    .clr_cnt_i      (clr3),
    .conflict_cnt_o (cnt3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed { int port; int due; } rsp_t;
  rsp_t sb[$];
  int   cyc;
  int   exp_cnt;

  logic [AW-1:0]   p_add  [NC];
  logic            p_we   [NC];
  logic [DW-1:0]   p_data [NC];
  logic [DW/8-1:0] p_be   [NC];

  task automatic apply_ports();
    for (int p = 0; p < NC; p++) begin
      bus.add_i[p]  = p_add[p];
      bus.we_i[p]   = p_we[p];
      bus.data_i[p] = p_data[p];
      bus.be_i[p]   = p_be[p];
    end
  endtask

  // one cycle on the 4-port instance; entered and left at a falling edge
  task automatic step(input logic [NC-1:0] req, input logic mg, input logic clr_v,
                      input logic [DW-1:0] rdata, input logic [NC-1:0] exp_gnt);
    logic [127:0]  exp_rd;
    logic [NC-1:0] exp_rv;
    int w;
    bus.req_i       = req;
    bus.mem_gnt_i   = mg;
    bus.mem_rdata_i = rdata;
    clr             = clr_v;
    #1;
    check_eq("gnt", bus.gnt_o, exp_gnt);
    check_eq("mem_req", bus.mem_req_o, |req);
    if (req == '0)
      check_eq("mem_idle", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o}, '0);
    w = -1;
    for (int p = 0; p < NC; p++) if (exp_gnt[p]) w = p;
    if (w >= 0)
      check_eq("mem_mux", {bus.mem_addr_o, bus.mem_wdata_o, bus.mem_be_o, bus.mem_we_o},
               {p_add[w], p_data[w], p_be[w], p_we[w]});
    exp_rv = '0;
    exp_rd = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_rv[sb[0].port]          = 1'b1;
      exp_rd[sb[0].port*DW +: DW] = rdata;
      void'(sb.pop_front());
    end
    check_eq("r_valid", bus.r_valid_o, exp_rv);
    check_eq("r_data", bus.r_data_o, exp_rd);
    check_eq("cnt", cnt, exp_cnt);
    if (w >= 0) sb.push_back('{port: w, due: cyc + 1});
    if (clr_v) exp_cnt = 0;
    else if ($countones(req) >= 2 && exp_cnt < 15) exp_cnt++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  logic [2:0] prev3;

  initial begin
    rst  = 1'b1;
    clr  = 1'b0;
    clr3 = 1'b0;
    for (int p = 0; p < NC; p++) begin
      p_add[p]  = 32'h1000 * (p + 1) + 32'h8;
      p_we[p]   = p[0];
      p_data[p] = 32'hA5A5_0000 + p;
      p_be[p]   = 4'hF >> p;
    end
    apply_ports();
    bus.req_i       = '0;
    bus.mem_gnt_i   = 1'b1;
    bus.mem_rdata_i = '0;
    bus3.req_i = '0; bus3.add_i = '0; bus3.we_i = '0; bus3.data_i = '0; bus3.be_i = '0;
    bus3.mem_gnt_i = 1'b1; bus3.mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    cyc     = 0;
    exp_cnt = 0;

    // idle after reset
    step('0, 1'b1, 1'b0, $urandom, '0);
    check_eq("cnt_reset", cnt, 0);

    // all four ports contend for 8 cycles
    for (int i = 0; i < 8; i++) step(4'hF, 1'b1, 1'b0, $urandom, 4'(1 << (i % 4)));
    step('0, 1'b1, 1'b0, $urandom, '0);
    check_eq("cnt_after_rr8", cnt, 8);

    // single read from port 2
    p_add[2] = 32'h40; p_we[2] = 1'b0;
    apply_ports();
    step(4'b0100, 1'b1, 1'b0, $urandom, 4'b0100);
    step('0, 1'b1, 1'b0, 32'hDEAD_BEEF, '0);

    // move the pointer to 1, then ports 1 and 3 under a 3-cycle bank stall
    step(4'b0001, 1'b1, 1'b0, $urandom, 4'b0001);
    for (int i = 0; i < 3; i++) step(4'b1010, 1'b0, 1'b0, $urandom, '0);
    step(4'b1010, 1'b1, 1'b0, $urandom, 4'b0010);
    step(4'b1000, 1'b1, 1'b0, $urandom, 4'b1000);
    step('0, 1'b1, 1'b0, $urandom, '0);
    check_eq("cnt_stall", cnt, 12);

    // saturation, then clear colliding with a conflict cycle
    step('0, 1'b1, 1'b1, $urandom, '0);
    for (int i = 0; i < 20; i++) step(4'b0011, 1'b0, 1'b0, $urandom, '0);
    check_eq("cnt_sat", cnt, 15);
    step(4'b0011, 1'b0, 1'b1, $urandom, '0);
    step('0, 1'b1, 1'b0, $urandom, '0);

    // same port granted again while its previous response returns
    step(4'b0001, 1'b1, 1'b0, $urandom, 4'b0001);
    step(4'b0001, 1'b1, 1'b0, $urandom, 4'b0001);
    step('0, 1'b1, 1'b0, $urandom, '0);

    // port 0 granted in the reset cycle: response dropped, pointer back to 0
    bus.req_i     = 4'b0001;
    bus.mem_gnt_i = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    cyc++;
    exp_cnt = 0;
    step('0, 1'b1, 1'b0, $urandom, '0);
    step(4'b0011, 1'b1, 1'b0, $urandom, 4'b0001);
    step(4'b1000, 1'b1, 1'b0, $urandom, 4'b1000);
    step('0, 1'b1, 1'b0, $urandom, '0);
    check_eq("sb_drained", sb.size(), 0);

    // 3-port instance: wrap of the pointer for a non-power-of-two count
    prev3 = '0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] req3;
      logic [2:0] exp3;
      req3 = (i < 6) ? 3'b111 : 3'b011;
      exp3 = (i < 6) ? 3'(1 << (i % 3)) : 3'(1 << (i - 6));
      bus3.req_i = req3;
      #1;
      check_eq("gnt3", bus3.gnt_o, exp3);
      check_eq("r_valid3", bus3.r_valid_o, prev3);
      prev3 = exp3;
      @(posedge clk);
      @(negedge clk);
    end
    bus3.req_i = '0;
    #1;
    check_eq("r_valid3_last", bus3.r_valid_o, prev3);
    check_eq("cnt3", cnt3, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
